// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arb_state_t;

  // Data accesses have strict priority over instruction fetches.
  function automatic arb_state_t grant_decision(input logic dreq, input logic ireq);
    if (dreq) begin
      return DGNT;
    end else if (ireq) begin
      return IGNT;
    end
    return IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of mem_arbiter signals for benches and wrappers.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      ihit;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dhit;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  modport arbif (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/wait_timer.sv
// Saturating wait counter; o_expire flags the cycle that would reach TIMEOUT.
module wait_timer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  assign o_expire = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr || o_expire) begin
      w_cnt_next = '0;
    end else if (i_en && (r_cnt != CNT_W'(TIMEOUT))) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between fetch and data paths; data wins ties.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  arb_state_t w_grant;
  logic       r_err;
  logic       w_granted;
  logic       w_access;
  logic       w_ramerr;
  logic       w_withdraw;
  logic       w_wait_en;
  logic       w_expire;

  assign w_grant    = grant_decision(dREN | dWEN, iREN);
  assign w_granted  = (r_state != IDLE);
  assign w_access   = w_granted && (ramstate == ACCESS);
  assign w_ramerr   = w_granted && (ramstate == ERROR);
  assign w_withdraw = ((r_state == DGNT) && !(dREN || dWEN)) ||
                      ((r_state == IGNT) && !iREN);
  assign w_wait_en  = w_granted && !w_access && !w_ramerr && !w_withdraw;
  assign err        = r_err;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .CLK      (CLK),
    .RST      (RST),
    .i_clr    (!w_wait_en),
    .i_en     (w_wait_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: w_state_next = w_grant;
      DGNT, IGNT: begin
        // Completion and withdrawal re-arbitrate immediately; faults park in IDLE.
        if (w_access || w_withdraw) begin
          w_state_next = w_grant;
        end else if (w_ramerr || w_expire) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_ramerr || w_expire) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    unique case (r_state)
      DGNT: begin
        // A simultaneous read and write request is treated as a write.
        ramREN   = dREN && !dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dhit     = (ramstate == ACCESS);
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iload   = ramload;
        ihit    = (ramstate == ACCESS);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; hits are checked by a scoreboard monitor.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  mem_arbiter_if u_if ();

  mem_arbiter #(
    .TIMEOUT (64),
    .CNT_W   (8)
  ) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (u_if.iREN),
    .iaddr    (u_if.iaddr),
    .iload    (u_if.iload),
    .ihit     (u_if.ihit),
    .dREN     (u_if.dREN),
    .dWEN     (u_if.dWEN),
    .daddr    (u_if.daddr),
    .dstore   (u_if.dstore),
    .dload    (u_if.dload),
    .dhit     (u_if.dhit),
    .ramREN   (u_if.ramREN),
    .ramWEN   (u_if.ramWEN),
    .ramaddr  (u_if.ramaddr),
    .ramstore (u_if.ramstore),
    .ramload  (u_if.ramload),
    .ramstate (u_if.ramstate),
    .err      (u_if.err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Every hit must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (u_if.ihit || u_if.dhit) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_hit: ihit=%0b dhit=%0b addr=%h, none expected",
                 u_if.ihit, u_if.dhit, u_if.ramaddr);
      end else begin
        exp_t e;
        logic [31:0] load;
        e = exp_q.pop_front();
        load = e.is_d ? u_if.dload : u_if.iload;
        if ((u_if.dhit !== e.is_d) || (u_if.ihit !== !e.is_d) ||
            (u_if.ramaddr !== e.addr) || (load !== e.data)) begin
          n_fail++;
          $display("FAIL hit_check: got ihit=%0b dhit=%0b addr=%h load=%h, expected %s addr=%h load=%h",
                   u_if.ihit, u_if.dhit, u_if.ramaddr, load, e.is_d ? "dhit" : "ihit",
                   e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic midcycle();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    midcycle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    RST           = 1'b1;
    u_if.iREN     = 1'b0;
    u_if.iaddr    = '0;
    u_if.dREN     = 1'b0;
    u_if.dWEN     = 1'b0;
    u_if.daddr    = '0;
    u_if.dstore   = '0;
    u_if.ramload  = '0;
    u_if.ramstate = FREE;
    #2;
    chk("rst_ramREN", 32'(u_if.ramREN), 32'h0);
    chk("rst_ramaddr", u_if.ramaddr, 32'h0);
    chk("rst_err", 32'(u_if.err), 32'h0);
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Fetch with two BUSY cycles then ACCESS.
    u_if.iREN = 1'b1; u_if.iaddr = 32'h4; u_if.ramstate = BUSY;
    tick(); #2;
    chk("f_c1_ramREN", 32'(u_if.ramREN), 32'h1);
    chk("f_c1_ramaddr", u_if.ramaddr, 32'h4);
    chk("f_c1_ihit", 32'(u_if.ihit), 32'h0);
    tick(); #2;
    chk("f_c2_ihit", 32'(u_if.ihit), 32'h0);
    tick();
    u_if.ramstate = ACCESS; u_if.ramload = 32'h2001_000A;
    push(1'b0, 32'h4, 32'h2001_000A);
    #2;
    chk("f_c3_ihit", 32'(u_if.ihit), 32'h1);
    midcycle();
    u_if.iREN = 1'b0; u_if.ramstate = FREE;
    tick(); #2;
    chk("f_idle_ramREN", 32'(u_if.ramREN), 32'h0);

    // Simultaneous data and fetch requests: back-to-back grants.
    midcycle();
    u_if.iREN = 1'b1; u_if.iaddr = 32'h8; u_if.dREN = 1'b1; u_if.daddr = 32'h100;
    u_if.ramstate = ACCESS; u_if.ramload = 32'h1111_1111;
    push(1'b1, 32'h100, 32'h1111_1111);
    push(1'b0, 32'h8, 32'h2222_2222);
    tick(); #2;
    chk("pri_dhit", 32'(u_if.dhit), 32'h1);
    chk("pri_d_addr", u_if.ramaddr, 32'h100);
    midcycle();
    u_if.dREN = 1'b0; u_if.ramload = 32'h2222_2222;
    tick(); #2;
    chk("pri_ihit", 32'(u_if.ihit), 32'h1);
    chk("pri_i_addr", u_if.ramaddr, 32'h8);
    midcycle();
    u_if.iREN = 1'b0; u_if.ramstate = FREE;
    tick();

    // Data write.
    u_if.dWEN = 1'b1; u_if.daddr = 32'h200; u_if.dstore = 32'hDEAD_BEEF;
    u_if.ramstate = BUSY; u_if.ramload = 32'h0;
    tick(); #2;
    chk("wr_ramWEN", 32'(u_if.ramWEN), 32'h1);
    chk("wr_ramREN", 32'(u_if.ramREN), 32'h0);
    chk("wr_ramstore", u_if.ramstore, 32'hDEAD_BEEF);
    chk("wr_busy_dhit", 32'(u_if.dhit), 32'h0);
    midcycle();
    u_if.ramstate = ACCESS;
    push(1'b1, 32'h200, 32'h0);
    tick(); #2;
    chk("wr_dhit", 32'(u_if.dhit), 32'h1);
    midcycle();
    u_if.dWEN = 1'b0; u_if.ramstate = FREE;
    tick();

    // Read and write together behave as a write.
    u_if.dREN = 1'b1; u_if.dWEN = 1'b1; u_if.daddr = 32'h204; u_if.dstore = 32'hCAFE_F00D;
    u_if.ramstate = ACCESS;
    push(1'b1, 32'h204, 32'h0);
    tick(); #2;
    chk("rw_ramREN", 32'(u_if.ramREN), 32'h0);
    chk("rw_ramWEN", 32'(u_if.ramWEN), 32'h1);
    chk("rw_ramstore", u_if.ramstore, 32'hCAFE_F00D);
    midcycle();
    u_if.dREN = 1'b0; u_if.dWEN = 1'b0; u_if.ramstate = FREE;
    tick();

    // Timeout after 64 granted BUSY cycles.
    u_if.iREN = 1'b1; u_if.iaddr = 32'hC; u_if.ramstate = BUSY;
    tick();
    for (int i = 2; i <= 64; i++) tick();
    #2;
    chk("to_c64_err", 32'(u_if.err), 32'h0);
    chk("to_c64_ramREN", 32'(u_if.ramREN), 32'h1);
    tick(); #2;
    chk("to_err", 32'(u_if.err), 32'h1);
    chk("to_idle_ramREN", 32'(u_if.ramREN), 32'h0);
    midcycle();
    u_if.iREN = 1'b0; u_if.ramstate = FREE;
    tick();
    u_if.iREN = 1'b1; u_if.iaddr = 32'h10; u_if.ramstate = ACCESS;
    u_if.ramload = 32'h3333_3333;
    push(1'b0, 32'h10, 32'h3333_3333);
    tick();
    midcycle();
    u_if.iREN = 1'b0; u_if.ramstate = FREE;
    tick(); #2;
    chk("to_err_sticky", 32'(u_if.err), 32'h1);

    // RAM ERROR during a data grant.
    do_reset();
    #2;
    chk("er_err_cleared", 32'(u_if.err), 32'h0);
    u_if.dREN = 1'b1; u_if.daddr = 32'h300; u_if.ramstate = ERROR;
    tick(); #2;
    chk("er_dhit", 32'(u_if.dhit), 32'h0);
    chk("er_ramREN", 32'(u_if.ramREN), 32'h1);
    tick(); #2;
    chk("er_err", 32'(u_if.err), 32'h1);
    chk("er_idle_ramREN", 32'(u_if.ramREN), 32'h0);
    midcycle();
    u_if.dREN = 1'b0; u_if.ramstate = FREE;
    tick();

    // Withdrawal after two BUSY cycles.
    do_reset();
    u_if.dREN = 1'b1; u_if.daddr = 32'h400; u_if.ramstate = BUSY;
    tick();
    tick(); #2;
    chk("wd_ramREN", 32'(u_if.ramREN), 32'h1);
    midcycle();
    u_if.dREN = 1'b0;
    tick(); #2;
    chk("wd_ramREN_drop", 32'(u_if.ramREN), 32'h0);
    chk("wd_ramaddr", u_if.ramaddr, 32'h0);
    chk("wd_err", 32'(u_if.err), 32'h0);

    // Asynchronous reset in the middle of a fetch grant.
    u_if.iREN = 1'b1; u_if.iaddr = 32'h14; u_if.ramstate = BUSY;
    tick(); #2;
    chk("ar_ramREN_pre", 32'(u_if.ramREN), 32'h1);
    midcycle();
    RST = 1'b1; u_if.ramstate = ACCESS;
    #1;
    chk("ar_ramREN", 32'(u_if.ramREN), 32'h0);
    chk("ar_ihit", 32'(u_if.ihit), 32'h0);
    #1;
    RST = 1'b0;
    u_if.ramload = 32'h4444_4444;
    push(1'b0, 32'h14, 32'h4444_4444);
    tick(); #2;
    chk("ar_after_ihit", 32'(u_if.ihit), 32'h1);
    midcycle();
    u_if.iREN = 1'b0; u_if.ramstate = FREE;
    tick();
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
